piso_serializer: RTL and testbench



---
 rtl/piso_serializer.sv | 72 +++++++
 tb/tb_piso_serializer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: takes an n-bit word over valid/ready and shifts it out LSB-first,
// one bit per clock, chaining words back-to-back so a downstream right-shift SIPO fills every n cycles.
module piso_serializer #(
    parameter int   n          = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [n-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         SO,
    output logic         so_valid,
    output logic         last_bit
);

    localparam int CW = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_nx;
    logic [n-1:0]  sreg, sreg_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          accept;

    // Ready depends only on registered state, so din_valid never loops back into din_ready.
    assign last_bit  = (state == SHIFT) && (cnt == CNT_LAST);
    assign din_ready = (state == IDLE) || last_bit;
    assign so_valid  = (state == SHIFT);
    assign SO        = (state == SHIFT) ? sreg[0] : IDLE_LEVEL;
    assign accept    = din_valid && din_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sreg  <= sreg_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sreg_nx  = sreg;
        cnt_nx   = cnt;
        if (accept) begin
            // Covers both the idle load and the gapless reload on the final bit.
            state_nx = SHIFT;
            sreg_nx  = din;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: ;
                SHIFT: begin
                    if (last_bit) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        sreg_nx = {1'b0, sreg[n-1:1]};
                        cnt_nx  = cnt + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed vector table and multi-cycle sequences on n=4, width sweep on
// n=2/n=8, and random traffic on n=4 against a bit-queue reference model.
module tb_piso_serializer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // n=4 instance
    logic [3:0] din4 = '0;
    logic vld4 = 1'b0, rdy4, so4, sov4, lb4;
    // n=2 instance
    logic [1:0] din2 = '0;
    logic vld2 = 1'b0, rdy2, so2, sov2, lb2;
    // n=8 instance
    logic [7:0] din8 = '0;
    logic vld8 = 1'b0, rdy8, so8, sov8, lb8;

    piso_serializer #(.n(4), .IDLE_LEVEL(1'b0)) dut4 (
        .clk(clk), .reset_n(reset_n), .din(din4), .din_valid(vld4),
        .din_ready(rdy4), .SO(so4), .so_valid(sov4), .last_bit(lb4));
    piso_serializer #(.n(2), .IDLE_LEVEL(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n), .din(din2), .din_valid(vld2),
        .din_ready(rdy2), .SO(so2), .so_valid(sov2), .last_bit(lb2));
    piso_serializer #(.n(8), .IDLE_LEVEL(1'b0)) dut8 (
        .clk(clk), .reset_n(reset_n), .din(din8), .din_valid(vld8),
        .din_ready(rdy8), .SO(so8), .so_valid(sov8), .last_bit(lb8));

    // Downstream right-shift SIPOs, clocked every cycle, SI enters at the MSB.
    logic [3:0] sipo4 = '0;
    logic [1:0] sipo2 = '0;
    logic [7:0] sipo8 = '0;
    always @(posedge clk) begin
        sipo4 <= {so4, sipo4[3:1]};
        sipo2 <= {so2, sipo2[1]};
        sipo8 <= {so8, sipo8[7:1]};
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string tag, input logic so, input logic sov, input logic lb, input logic rdy);
        chk({tag, ".SO"},        8'(so4),  8'(so));
        chk({tag, ".so_valid"},  8'(sov4), 8'(sov));
        chk({tag, ".last_bit"},  8'(lb4),  8'(lb));
        chk({tag, ".din_ready"}, 8'(rdy4), 8'(rdy));
    endtask

    typedef struct {
        logic       rst_n;
        logic       vld;
        logic [3:0] din;
        logic       so, sov, lb, rdy;
        logic       chk_q;
        logic [3:0] q;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic v, input logic [3:0] d, input logic so,
                       input logic sov, input logic lb, input logic rdy,
                       input logic cq = 1'b0, input logic [3:0] q = 4'h0);
        vec_t e;
        e.rst_n = r; e.vld = v; e.din = d; e.so = so; e.sov = sov; e.lb = lb; e.rdy = rdy;
        e.chk_q = cq; e.q = q;
        tbl.push_back(e);
    endtask

    // Reference model: queue of bits still to be emitted on SO.
    logic mq[$];

    initial begin
        // reset then idle
        for (int i = 0; i < 3; i++) add(0, 0, 4'h0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) add(1, 0, 4'h0, 0, 0, 0, 1);
        // single word 1011
        add(1, 1, 4'hB, 0, 0, 0, 1);
        add(1, 0, 4'h0, 1, 1, 0, 0);
        add(1, 0, 4'h0, 1, 1, 0, 0);
        add(1, 0, 4'h0, 0, 1, 0, 0);
        add(1, 0, 4'h0, 1, 1, 1, 1);
        add(1, 0, 4'h0, 0, 0, 0, 1, 1, 4'hB);
        // back-to-back A then 5
        add(1, 1, 4'hA, 0, 0, 0, 1);
        add(1, 1, 4'hA, 0, 1, 0, 0);
        add(1, 1, 4'hA, 1, 1, 0, 0);
        add(1, 1, 4'hA, 0, 1, 0, 0);
        add(1, 1, 4'h5, 1, 1, 1, 1);
        add(1, 0, 4'h0, 1, 1, 0, 0, 1, 4'hA);
        add(1, 0, 4'h0, 0, 1, 0, 0);
        add(1, 0, 4'h0, 1, 1, 0, 0);
        add(1, 0, 4'h0, 0, 1, 1, 1);
        add(1, 0, 4'h0, 0, 0, 0, 1, 1, 4'h5);
        // din changes mid-frame are ignored until the last-bit edge
        add(1, 1, 4'h3, 0, 0, 0, 1);
        add(1, 1, 4'hC, 1, 1, 0, 0);
        add(1, 1, 4'hC, 1, 1, 0, 0);
        add(1, 1, 4'hC, 0, 1, 0, 0);
        add(1, 1, 4'hC, 0, 1, 1, 1);
        add(1, 0, 4'h0, 0, 1, 0, 0, 1, 4'h3);
        add(1, 0, 4'h0, 0, 1, 0, 0);
        add(1, 0, 4'h0, 1, 1, 0, 0);
        add(1, 0, 4'h0, 1, 1, 1, 1);
        add(1, 0, 4'h0, 0, 0, 0, 1, 1, 4'hC);

        foreach (tbl[i]) begin
            @(negedge clk);
            reset_n = tbl[i].rst_n; vld4 = tbl[i].vld; din4 = tbl[i].din;
            #1;
            chk4($sformatf("tbl%0d", i), tbl[i].so, tbl[i].sov, tbl[i].lb, tbl[i].rdy);
            if (tbl[i].chk_q) chk($sformatf("tbl%0d.sipo", i), 8'(sipo4), 8'(tbl[i].q));
        end

        // asynchronous reset mid-frame, then a clean frame
        @(negedge clk); din4 = 4'hF; vld4 = 1; #1 chk4("rst.acc", 0, 0, 0, 1);
        @(negedge clk); din4 = 4'h0; vld4 = 0; #1 chk4("rst.b0", 1, 1, 0, 0);
        @(negedge clk); #1 chk4("rst.b1", 1, 1, 0, 0);
        @(posedge clk); #2 reset_n = 0;
        #1 chk4("rst.async", 0, 0, 0, 1);
        @(negedge clk); reset_n = 1; din4 = 4'h6; vld4 = 1; #1 chk4("rst.ready", 0, 0, 0, 1);
        @(negedge clk); vld4 = 0; din4 = 4'h0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1 chk4($sformatf("rst.post%0d", k), 1'((4'h6 >> k) & 1), 1, k == 3, k == 3);
        end
        @(negedge clk); #1 chk("rst.sipo", 8'(sipo4), 8'h06);

        // width sweep: n=2 word 2'b10, n=8 word 8'hA5, launched together
        @(negedge clk); din2 = 2'b10; vld2 = 1; din8 = 8'hA5; vld8 = 1;
        #1 chk("w.rdy2", 8'(rdy2), 8'h01);
        chk("w.rdy8", 8'(rdy8), 8'h01);
        @(negedge clk); vld2 = 0; vld8 = 0; din2 = '0; din8 = '0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("w8.SO%0d", k), 8'(so8), 8'((8'hA5 >> k) & 1));
            chk($sformatf("w8.lb%0d", k), 8'(lb8), 8'(k == 7));
            chk($sformatf("w8.sov%0d", k), 8'(sov8), 8'h01);
            if (k < 2) begin
                chk($sformatf("w2.SO%0d", k), 8'(so2), 8'((2'b10 >> k) & 1));
                chk($sformatf("w2.lb%0d", k), 8'(lb2), 8'(k == 1));
                chk($sformatf("w2.sov%0d", k), 8'(sov2), 8'h01);
            end else begin
                chk($sformatf("w2.idle%0d", k), 8'({so2, sov2, rdy2}), 8'b001);
                if (k == 2) chk("w2.sipo", 8'(sipo2), 8'h02);
            end
        end
        @(negedge clk); #1 chk("w8.sipo", 8'(sipo8), 8'hA5);
        chk("w8.idle", 8'({so8, sov8, lb8, rdy8}), 8'b0001);

        // random traffic on n=4 against the bit-queue model
        mq.delete();
        for (int c = 0; c < 400; c++) begin
            logic e_so, e_sov, e_lb, e_rdy, acc;
            @(negedge clk);
            reset_n = ($urandom_range(0, 39) != 0);
            vld4    = ($urandom_range(0, 3) != 0);
            din4    = 4'($urandom);
            if (!reset_n) mq.delete();
            #1;
            e_sov = (mq.size() > 0);
            e_so  = e_sov ? mq[0] : 1'b0;
            e_lb  = (mq.size() == 1);
            e_rdy = (mq.size() <= 1);
            chk4($sformatf("rnd%0d", c), e_so, e_sov, e_lb, e_rdy);
            acc = reset_n && vld4 && e_rdy;
            if (mq.size() > 0) void'(mq.pop_front());
            if (acc) for (int k = 0; k < 4; k++) mq.push_back(din4[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
